// File: rtl/axi_pkg.sv
// Shared AXI4 constants, size encoding and FSM state types
// for the CPU memory-side burst master.
package axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_XFER,
    W_RESP
  } wr_state_e;

  // AXI size field: log2 of the beat width in bytes
  function automatic logic [2:0] size_log2(input int unsigned bytes);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (bytes == (32'd1 << i)) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_beat_counter.sv
// Per-channel beat counter: loads burst length, steps on
// each data handshake and flags the final beat.
module axi_beat_counter (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       clr,
  input  logic       step,
  input  logic [7:0] len,
  output logic       is_last
);

  logic [7:0] cnt_q;
  logic [7:0] len_q;

  // load on request accept, advance on each beat
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt_q <= '0;
      len_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
      len_q <= len;
    end else if (step) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign is_last = (cnt_q == len_q);

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 INCR burst master with independent read and write
// engines between the LSU/cache and the crossbar.
module axi_burst_master
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int RD_ID  = 0,
  parameter int WR_ID  = 1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                rd_req_valid,
  output logic                rd_req_ready,
  input  logic [ADDR_W-1:0]   rd_req_addr,
  input  logic [7:0]          rd_req_len,
  input  logic [2:0]          rd_req_size,
  output logic                rd_beat_valid,
  input  logic                rd_beat_ready,
  output logic [DATA_W-1:0]   rd_beat_data,
  output logic                rd_beat_last,
  output logic                rd_beat_err,
  input  logic                wr_req_valid,
  output logic                wr_req_ready,
  input  logic [ADDR_W-1:0]   wr_req_addr,
  input  logic [7:0]          wr_req_len,
  input  logic [2:0]          wr_req_size,
  input  logic                wr_beat_valid,
  output logic                wr_beat_ready,
  input  logic [DATA_W-1:0]   wr_beat_data,
  input  logic [DATA_W/8-1:0] wr_beat_strb,
  output logic                wr_done,
  output logic                wr_err,
  output logic [ID_W-1:0]     m_arid,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic                m_arlock,
  output logic [3:0]          m_arcache,
  output logic [2:0]          m_arprot,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [ID_W-1:0]     m_rid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [ID_W-1:0]     m_awid,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_awlock,
  output logic [3:0]          m_awcache,
  output logic [2:0]          m_awprot,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ID_W-1:0]     m_wid,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [ID_W-1:0]     m_bid,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  rd_state_e           r_state, r_state_d;
  wr_state_e           w_state, w_state_d;
  logic [ADDR_W-1:0]   ar_addr_q, aw_addr_q;
  logic [7:0]          ar_len_q, aw_len_q;
  logic [2:0]          ar_size_q, aw_size_q;
  logic                aw_done_q, w_done_q;
  logic                r_accept, w_accept;
  logic                r_hs, w_hs, aw_hs;
  logic                r_is_last, w_is_last;
  logic                unused_ok;

  assign r_accept = rd_req_valid & rd_req_ready;
  assign w_accept = wr_req_valid & wr_req_ready;
  assign r_hs     = m_rvalid & m_rready;
  assign w_hs     = m_wvalid & m_wready;
  assign aw_hs    = m_awvalid & m_awready;

  assign m_arid    = ID_W'(RD_ID);
  assign m_araddr  = ar_addr_q;
  assign m_arlen   = ar_len_q;
  assign m_arsize  = ar_size_q;
  assign m_arburst = BURST_INCR;
  assign m_arlock  = 1'b0;
  assign m_arcache = 4'b0000;
  assign m_arprot  = 3'b000;

  assign m_awid    = ID_W'(WR_ID);
  assign m_wid     = ID_W'(WR_ID);
  assign m_awaddr  = aw_addr_q;
  assign m_awlen   = aw_len_q;
  assign m_awsize  = aw_size_q;
  assign m_awburst = BURST_INCR;
  assign m_awlock  = 1'b0;
  assign m_awcache = 4'b0000;
  assign m_awprot  = 3'b000;

  assign rd_beat_data = m_rdata;
  assign rd_beat_last = m_rlast;
  assign m_wdata      = wr_beat_data;
  assign m_wstrb      = wr_beat_strb;

  // IDs are fixed per channel; low resp bits carry no error info
  assign unused_ok = ^{m_rid, m_bid, m_rresp[0], m_bresp[0]};

  axi_beat_counter u_rd_cnt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (r_accept),
    .step    (r_hs),
    .len     (rd_req_len),
    .is_last (r_is_last)
  );

  axi_beat_counter u_wr_cnt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (w_accept),
    .step    (w_hs),
    .len     (wr_req_len),
    .is_last (w_is_last)
  );

  // read state and latched AR payload
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state   <= R_IDLE;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      ar_size_q <= '0;
    end else begin
      r_state <= r_state_d;
      if (r_accept) begin
        ar_addr_q <= rd_req_addr;
        ar_len_q  <= rd_req_len;
        ar_size_q <= rd_req_size;
      end
    end
  end

  // read next-state, AR valid and R pass-through gating
  always_comb begin
    r_state_d     = r_state;
    rd_req_ready  = 1'b0;
    m_arvalid     = 1'b0;
    m_rready      = 1'b0;
    rd_beat_valid = 1'b0;
    rd_beat_err   = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        rd_req_ready = aresetn;
        if (rd_req_valid && aresetn) r_state_d = R_ADDR;
      end
      R_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) r_state_d = R_DATA;
      end
      R_DATA: begin
        m_rready      = rd_beat_ready;
        rd_beat_valid = m_rvalid;
        rd_beat_err   = m_rvalid &
                        (m_rresp[1] | (m_rlast ^ r_is_last));
        if (r_hs && r_is_last) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // write state, latched AW payload and completion flags
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state   <= W_IDLE;
      aw_addr_q <= '0;
      aw_len_q  <= '0;
      aw_size_q <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      w_state <= w_state_d;
      if (w_accept) begin
        aw_addr_q <= wr_req_addr;
        aw_len_q  <= wr_req_len;
        aw_size_q <= wr_req_size;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs && w_is_last) w_done_q <= 1'b1;
      end
    end
  end

  // write next-state; AW and W run concurrently in W_XFER
  always_comb begin
    w_state_d     = w_state;
    wr_req_ready  = 1'b0;
    m_awvalid     = 1'b0;
    m_wvalid      = 1'b0;
    m_wlast       = 1'b0;
    wr_beat_ready = 1'b0;
    m_bready      = 1'b0;
    wr_done       = 1'b0;
    wr_err        = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        wr_req_ready = aresetn;
        if (wr_req_valid && aresetn) w_state_d = W_XFER;
      end
      W_XFER: begin
        m_awvalid     = ~aw_done_q;
        m_wvalid      = wr_beat_valid & ~w_done_q;
        wr_beat_ready = m_wready & ~w_done_q;
        m_wlast       = w_is_last;
        if ((aw_done_q || m_awready) &&
            (w_done_q || (w_hs && w_is_last)))
          w_state_d = W_RESP;
      end
      W_RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          wr_done   = 1'b1;
          wr_err    = m_bresp[1];
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed self-checking bench for axi_burst_master:
// reset, read/write bursts, errors, concurrency, reset abort.
module tb_axi_burst_master;
  import axi_pkg::*;

  logic        aclk;
  logic        aresetn;
  logic        rd_req_valid, rd_req_ready;
  logic [31:0] rd_req_addr;
  logic [7:0]  rd_req_len;
  logic [2:0]  rd_req_size;
  logic        rd_beat_valid, rd_beat_ready;
  logic [31:0] rd_beat_data;
  logic        rd_beat_last, rd_beat_err;
  logic        wr_req_valid, wr_req_ready;
  logic [31:0] wr_req_addr;
  logic [7:0]  wr_req_len;
  logic [2:0]  wr_req_size;
  logic        wr_beat_valid, wr_beat_ready;
  logic [31:0] wr_beat_data;
  logic [3:0]  wr_beat_strb;
  logic        wr_done, wr_err;
  logic [3:0]  m_arid, m_rid, m_awid, m_wid, m_bid;
  logic [31:0] m_araddr, m_awaddr, m_rdata, m_wdata;
  logic [7:0]  m_arlen, m_awlen;
  logic [2:0]  m_arsize, m_awsize, m_arprot, m_awprot;
  logic [1:0]  m_arburst, m_awburst, m_rresp, m_bresp;
  logic        m_arlock, m_awlock;
  logic [3:0]  m_arcache, m_awcache, m_wstrb;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic        m_bvalid, m_bready;

  int checks = 0;
  int errors = 0;

  axi_burst_master dut (
    .aclk(aclk), .aresetn(aresetn),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
    .rd_req_size(rd_req_size),
    .rd_beat_valid(rd_beat_valid), .rd_beat_ready(rd_beat_ready),
    .rd_beat_data(rd_beat_data), .rd_beat_last(rd_beat_last),
    .rd_beat_err(rd_beat_err),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len),
    .wr_req_size(wr_req_size),
    .wr_beat_valid(wr_beat_valid), .wr_beat_ready(wr_beat_ready),
    .wr_beat_data(wr_beat_data), .wr_beat_strb(wr_beat_strb),
    .wr_done(wr_done), .wr_err(wr_err),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arlock(m_arlock), .m_arcache(m_arcache),
    .m_arprot(m_arprot), .m_arvalid(m_arvalid),
    .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awlock(m_awlock), .m_awcache(m_awcache),
    .m_awprot(m_awprot), .m_awvalid(m_awvalid),
    .m_awready(m_awready),
    .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic step;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset;
    aresetn = 0;
    rd_req_valid = 0; rd_req_addr = 0; rd_req_len = 0;
    rd_req_size = 0; rd_beat_ready = 0;
    wr_req_valid = 0; wr_req_addr = 0; wr_req_len = 0;
    wr_req_size = 0; wr_beat_valid = 0; wr_beat_data = 0;
    wr_beat_strb = 0;
    m_arready = 0; m_rid = 0; m_rdata = 0; m_rresp = 0;
    m_rlast = 0; m_rvalid = 0; m_awready = 0; m_wready = 0;
    m_bid = 1; m_bresp = 0; m_bvalid = 0;
    step; step;
    checks++;
    if ({rd_req_ready, wr_req_ready, m_arvalid, m_awvalid,
         m_bready, wr_done, m_wvalid} !== 7'b0 ||
        m_araddr !== 32'h0 || m_awaddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b/%b arv=%b awv=%b araddr=%h need all 0",
               rd_req_ready, wr_req_ready, m_arvalid, m_awvalid, m_araddr);
    end
    checks++;
    if (m_arburst !== 2'b01 || m_arid !== 4'd0 ||
        m_awid !== 4'd1 || m_wid !== 4'd1 ||
        m_arcache !== 4'd0 || m_awprot !== 3'd0) begin
      errors++;
      $display("FAIL const_outputs: burst=%b arid=%0d awid=%0d wid=%0d need 01/0/1/1",
               m_arburst, m_arid, m_awid, m_wid);
    end
    aresetn = 1;
    step;
    checks++;
    if (rd_req_ready !== 1'b1 || wr_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: rd_rdy=%b wr_rdy=%b need 1/1",
               rd_req_ready, wr_req_ready);
    end
  endtask

  task automatic test_single_read;
    rd_req_valid = 1; rd_req_addr = 32'h1000; rd_req_len = 0;
    rd_req_size = size_log2(4);
    #1;
    checks++;
    if (rd_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_accept: ready=%b need 1", rd_req_ready);
    end
    step;
    rd_req_valid = 0; rd_req_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (m_arvalid !== 1'b1 || m_araddr !== 32'h1000 ||
          m_arlen !== 8'd0 || m_arsize !== 3'd2) begin
        errors++;
        $display("FAIL ar_hold%0d: arv=%b addr=%h len=%0d size=%0d need 1/1000/0/2",
                 i, m_arvalid, m_araddr, m_arlen, m_arsize);
      end
      step;
    end
    m_arready = 1;
    step;
    m_arready = 0;
    checks++;
    if (m_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL ar_drop: arv=%b need 0", m_arvalid);
    end
    m_rvalid = 1; m_rdata = 32'hDEADBEEF; m_rlast = 1;
    m_rresp = RESP_OKAY; rd_beat_ready = 1;
    #1;
    checks++;
    if (rd_beat_valid !== 1'b1 || rd_beat_data !== 32'hDEADBEEF ||
        rd_beat_last !== 1'b1 || rd_beat_err !== 1'b0 ||
        m_rready !== 1'b1) begin
      errors++;
      $display("FAIL rd_single_beat: v=%b d=%h l=%b e=%b need 1/deadbeef/1/0",
               rd_beat_valid, rd_beat_data, rd_beat_last, rd_beat_err);
    end
    step;
    m_rvalid = 0; m_rlast = 0; rd_beat_ready = 0;
    checks++;
    if (rd_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_back_idle: ready=%b need 1", rd_req_ready);
    end
  endtask

  task automatic test_read_burst(input logic [7:0] len,
                                 input int rlast_beat,
                                 input int exp_errs,
                                 input string name);
    int k;
    int cyc;
    int errs_seen;
    logic exp_err;
    k = 0; cyc = 0; errs_seen = 0;
    rd_req_valid = 1; rd_req_addr = 32'h2000; rd_req_len = len;
    rd_req_size = size_log2(4);
    step;
    rd_req_valid = 0;
    m_arready = 1;
    step;
    m_arready = 0;
    while (k <= int'(len) && cyc < 64) begin
      m_rvalid = 1;
      m_rdata = 32'h100 + k;
      m_rlast = (k == rlast_beat);
      m_rresp = RESP_OKAY;
      rd_beat_ready = (cyc % 2 == 1);
      #1;
      if (rd_beat_valid && rd_beat_ready) begin
        exp_err = (k == rlast_beat) != (k == int'(len));
        checks++;
        if (rd_beat_data !== 32'h100 + k ||
            rd_beat_last !== (k == rlast_beat) ||
            rd_beat_err !== exp_err) begin
          errors++;
          $display("FAIL %s_beat%0d: d=%h l=%b e=%b need %h/%b/%b",
                   name, k, rd_beat_data, rd_beat_last, rd_beat_err,
                   32'h100 + k, (k == rlast_beat), exp_err);
        end
        if (rd_beat_err) errs_seen++;
        k++;
      end
      step;
      cyc++;
    end
    m_rvalid = 0; m_rlast = 0; rd_beat_ready = 0;
    checks++;
    if (k !== int'(len) + 1 || errs_seen !== exp_errs ||
        rd_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: beats=%0d errs=%0d rdy=%b need %0d/%0d/1",
               name, k, errs_seen, rd_req_ready, int'(len) + 1, exp_errs);
    end
  endtask

  task automatic test_write(input logic [7:0] len,
                            input bit aw_late,
                            input logic [1:0] bresp,
                            input string name);
    int k;
    int cyc;
    logic [3:0] exp_strb;
    k = 0; cyc = 0;
    wr_req_valid = 1; wr_req_addr = 32'h3000; wr_req_len = len;
    wr_req_size = size_log2(4);
    step;
    wr_req_valid = 0;
    checks++;
    if (m_awvalid !== 1'b1 || m_awaddr !== 32'h3000 ||
        m_awlen !== len || m_awsize !== 3'd2) begin
      errors++;
      $display("FAIL %s_aw: v=%b addr=%h len=%0d need 1/3000/%0d",
               name, m_awvalid, m_awaddr, m_awlen, len);
    end
    m_awready = !aw_late;
    while (k <= int'(len) && cyc < 64) begin
      exp_strb = (k == 1) ? 4'b0011 : 4'b1111;
      wr_beat_valid = 1;
      wr_beat_data = 32'hA0 + k;
      wr_beat_strb = exp_strb;
      m_wready = (cyc >= 2);
      #1;
      if (m_wvalid && m_wready) begin
        checks++;
        if (m_wdata !== 32'hA0 + k || m_wstrb !== exp_strb ||
            m_wlast !== (k == int'(len)) || wr_beat_ready !== 1'b1) begin
          errors++;
          $display("FAIL %s_w%0d: d=%h s=%b l=%b r=%b need %h/%b/%b/1",
                   name, k, m_wdata, m_wstrb, m_wlast, wr_beat_ready,
                   32'hA0 + k, exp_strb, (k == int'(len)));
        end
        k++;
      end
      step;
      cyc++;
    end
    wr_beat_valid = 0; m_wready = 0; m_awready = 0;
    if (aw_late) begin
      checks++;
      if (m_awvalid !== 1'b1 || m_bready !== 1'b0) begin
        errors++;
        $display("FAIL %s_aw_wait: awv=%b bready=%b need 1/0",
                 name, m_awvalid, m_bready);
      end
      m_awready = 1;
      step;
      m_awready = 0;
    end
    checks++;
    if (k !== int'(len) + 1 || m_bready !== 1'b1 ||
        m_awvalid !== 1'b0 || wr_beat_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_resp_wait: beats=%0d bready=%b awv=%b need %0d/1/0",
               name, k, m_bready, m_awvalid, int'(len) + 1);
    end
    m_bvalid = 1; m_bresp = bresp;
    #1;
    checks++;
    if (wr_done !== 1'b1 || wr_err !== bresp[1]) begin
      errors++;
      $display("FAIL %s_done: done=%b err=%b need 1/%b",
               name, wr_done, wr_err, bresp[1]);
    end
    step;
    m_bvalid = 0; m_bresp = 0;
    checks++;
    if (wr_done !== 1'b0 || wr_req_ready !== 1'b1 ||
        m_bready !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: done=%b rdy=%b bready=%b need 0/1/0",
               name, wr_done, wr_req_ready, m_bready);
    end
  endtask

  task automatic test_concurrent;
    int rk;
    int wk;
    int dn;
    int cyc;
    rk = 0; wk = 0; dn = 0; cyc = 0;
    rd_req_valid = 1; rd_req_addr = 32'h4000; rd_req_len = 3;
    wr_req_valid = 1; wr_req_addr = 32'h5000; wr_req_len = 3;
    step;
    rd_req_valid = 0; wr_req_valid = 0;
    m_arready = 1; m_awready = 1; m_wready = 1; rd_beat_ready = 1;
    while ((rk < 4 || dn < 1) && cyc < 40) begin
      m_rvalid = (rk < 4);
      m_rdata = 32'h200 + rk;
      m_rlast = (rk == 3);
      wr_beat_valid = (wk < 4);
      wr_beat_data = 32'h300 + wk;
      wr_beat_strb = 4'hF;
      m_bvalid = (wk > 3);
      m_bresp = RESP_OKAY;
      #1;
      if (rd_beat_valid && rd_beat_ready) begin
        checks++;
        if (rd_beat_data !== 32'h200 + rk || rd_beat_err !== 1'b0) begin
          errors++;
          $display("FAIL conc_r%0d: d=%h e=%b need %h/0",
                   rk, rd_beat_data, rd_beat_err, 32'h200 + rk);
        end
        rk++;
      end
      if (m_wvalid && m_wready) begin
        checks++;
        if (m_wdata !== 32'h300 + wk || m_wlast !== (wk == 3)) begin
          errors++;
          $display("FAIL conc_w%0d: d=%h l=%b need %h/%b",
                   wk, m_wdata, m_wlast, 32'h300 + wk, (wk == 3));
        end
        wk++;
      end
      if (wr_done) begin
        checks++;
        if (wr_err !== 1'b0) begin
          errors++;
          $display("FAIL conc_wr_err: err=%b need 0", wr_err);
        end
        dn++;
      end
      step;
      cyc++;
    end
    m_rvalid = 0; m_rlast = 0; wr_beat_valid = 0; m_bvalid = 0;
    m_arready = 0; m_awready = 0; m_wready = 0; rd_beat_ready = 0;
    checks++;
    if (rk !== 4 || wk !== 4 || dn !== 1 ||
        rd_req_ready !== 1'b1 || wr_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL conc_done: r=%0d w=%0d done=%0d rdy=%b/%b need 4/4/1/1/1",
               rk, wk, dn, rd_req_ready, wr_req_ready);
    end
  endtask

  task automatic test_reset_mid_write;
    wr_req_valid = 1; wr_req_addr = 32'h6000; wr_req_len = 3;
    rd_req_valid = 1; rd_req_addr = 32'h7000; rd_req_len = 1;
    step;
    wr_req_valid = 0; rd_req_valid = 0;
    wr_beat_valid = 1; wr_beat_strb = 4'hF; m_wready = 1;
    wr_beat_data = 32'h11;
    step;
    wr_beat_data = 32'h22;
    step;
    checks++;
    if (m_awvalid !== 1'b1 || m_arvalid !== 1'b1 ||
        m_wvalid !== 1'b1) begin
      errors++;
      $display("FAIL pre_abort: awv=%b arv=%b wv=%b need 1/1/1",
               m_awvalid, m_arvalid, m_wvalid);
    end
    aresetn = 0;
    step;
    checks++;
    if ({m_awvalid, m_arvalid, m_wvalid, rd_beat_valid, wr_done,
         m_bready, rd_req_ready, wr_req_ready} !== 8'b0) begin
      errors++;
      $display("FAIL abort_valids: awv=%b arv=%b wv=%b rdy=%b/%b need 0",
               m_awvalid, m_arvalid, m_wvalid, rd_req_ready, wr_req_ready);
    end
    aresetn = 1;
    wr_beat_valid = 0; m_wready = 0;
    step;
    checks++;
    if (rd_req_ready !== 1'b1 || wr_req_ready !== 1'b1 ||
        m_awaddr !== 32'h0 || m_araddr !== 32'h0) begin
      errors++;
      $display("FAIL abort_release: rdy=%b/%b awaddr=%h araddr=%h need 1/1/0/0",
               rd_req_ready, wr_req_ready, m_awaddr, m_araddr);
    end
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_read_burst(8'd7, 7, 0, "rd8");
    test_read_burst(8'd7, 5, 2, "rd8_badlast");
    test_write(8'd3, 1'b1, RESP_OKAY, "wr4");
    test_write(8'd1, 1'b0, RESP_SLVERR, "wr_slverr");
    test_concurrent;
    test_reset_mid_write;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
